// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline: load-use stalls,
// taken-branch flushes, EX operand forwarding and the WB-to-ID bypass.
module pipeline_hazard_ctrl #(
  parameter int ASIZE        = 5,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [ASIZE-1:0] id_rs,
  input  logic [ASIZE-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wen,
  input  logic [ASIZE-1:0] id_waddr,
  input  logic             id_memread,
  input  logic             ex_taken,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             id_byp_a,
  output logic             id_byp_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  // EX slot keeps full decode info; MEM/WB only need destination state.
  // *_wr already folds in "writes a non-zero register".
  logic             ex_valid;
  logic             ex_wr;
  logic [ASIZE-1:0] ex_waddr;
  logic             ex_memread;
  logic [ASIZE-1:0] ex_rs;
  logic [ASIZE-1:0] ex_rt;
  logic             ex_use_rs;
  logic             ex_use_rt;

  logic             mem_wr;
  logic [ASIZE-1:0] mem_waddr;
  logic             mem_memread;

  logic             wb_wr;
  logic [ASIZE-1:0] wb_waddr;

  logic [1:0]       fcnt_q;
  logic             load_use;
  logic             taken;

  assign load_use = id_valid && ex_valid && ex_memread && ex_wr &&
                    ((id_use_rs && (id_rs == ex_waddr)) ||
                     (id_use_rt && (id_rt == ex_waddr)));

  // A branch is only accepted outside an active flush window.
  assign taken  = ex_taken && ex_valid && (fcnt_q == 2'd0);
  assign flush  = taken || (fcnt_q != 2'd0);
  assign stall  = load_use && !flush;
  assign bubble = load_use || flush;

  assign id_byp_a = wb_wr && id_use_rs && (wb_waddr == id_rs);
  assign id_byp_b = wb_wr && id_use_rt && (wb_waddr == id_rt);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (ex_valid) begin
      if (ex_use_rs) begin
        if (mem_wr && !mem_memread && (mem_waddr == ex_rs)) fwd_a = 2'b01;
        else if (wb_wr && (wb_waddr == ex_rs))             fwd_a = 2'b10;
      end
      if (ex_use_rt) begin
        if (mem_wr && !mem_memread && (mem_waddr == ex_rt)) fwd_b = 2'b01;
        else if (wb_wr && (wb_waddr == ex_rt))             fwd_b = 2'b10;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so all slots shift from the
  // values they held before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      mem_wr    <= 1'b0;
      wb_wr     <= 1'b0;
      fcnt_q    <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_valid <= id_valid && !bubble;
      mem_wr   <= ex_valid && ex_wr;
      wb_wr    <= mem_wr;

      if (taken)               fcnt_q <= FLUSH_LOAD;
      else if (fcnt_q != 2'd0) fcnt_q <= fcnt_q - 2'd1;

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (taken && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // NOTE: payload fields are qualified by the reset-cleared valid/wr bits,
  // so they carry no reset and stay plain data registers.
  always_ff @(posedge clk) begin
    ex_wr       <= id_wen && (id_waddr != '0);
    ex_waddr    <= id_waddr;
    ex_memread  <= id_memread;
    ex_rs       <= id_rs;
    ex_rt       <= id_rt;
    ex_use_rs   <= id_use_rs;
    ex_use_rt   <= id_use_rt;
    mem_waddr   <= ex_waddr;
    mem_memread <= ex_memread;
    wb_waddr    <= mem_waddr;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized scoreboard bench for pipeline_hazard_ctrl; a second narrow-counter
// instance on the same stimulus exercises counter saturation.
module tb_pipeline_hazard_ctrl;

  localparam int ASIZE = 5;
  localparam int FLUSH_CYCLES = 2;
  localparam int SMALL_W = 4;

  logic clk = 1'b0;
  logic rst, id_valid, id_use_rs, id_use_rt, id_wen, id_memread, ex_taken;
  logic [ASIZE-1:0] id_rs, id_rt, id_waddr;

  logic stall, bubble, flush, id_byp_a, id_byp_b;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_stall, s_bubble, s_flush, s_byp_a, s_byp_b;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic [SMALL_W-1:0] s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.ASIZE(ASIZE), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen),
    .id_waddr(id_waddr), .id_memread(id_memread), .ex_taken(ex_taken),
    .stall(stall), .bubble(bubble), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_a(id_byp_a), .id_byp_b(id_byp_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

  pipeline_hazard_ctrl #(.ASIZE(ASIZE), .FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(SMALL_W)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wen(id_wen),
    .id_waddr(id_waddr), .id_memread(id_memread), .ex_taken(ex_taken),
    .stall(s_stall), .bubble(s_bubble), .flush(s_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .id_byp_a(s_byp_a), .id_byp_b(s_byp_b),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt));

  typedef struct {
    bit valid, wen, memread, use_rs, use_rt;
    int waddr, rs, rt;
  } instr_t;

  typedef struct {
    int cycle;
    bit stall, bubble, flush, byp_a, byp_b;
    int fwd_a, fwd_b, stall_cnt, flush_cnt, s_stall_cnt, s_flush_cnt;
  } exp_t;

  exp_t exp_q[$];
  instr_t pipe[$];      // [0]=EX, [1]=MEM, [2]=WB
  bit model_known = 0;
  int flush_left, n_stall, n_flush;
  int cycle = 0;
  int checks = 0, errors = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit writes(instr_t s, int r);
    return s.valid && s.wen && (r != 0) && (s.waddr == r);
  endfunction

  function automatic int fwd_src(int r, bit used);
    if (!pipe[0].valid || !used) return 0;
    if (writes(pipe[1], r) && !pipe[1].memread) return 1;
    if (writes(pipe[2], r)) return 2;
    return 0;
  endfunction

  function automatic int sat(int n, int width);
    int lim = (1 << width) - 1;
    return (n > lim) ? lim : n;
  endfunction

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic step(input bit r, input instr_t id, input bit tk);
    instr_t bub;
    exp_t e;
    bit lu, acc;
    @(negedge clk);
    #1;
    rst = r; id_valid = id.valid; id_rs = ASIZE'(id.rs); id_rt = ASIZE'(id.rt);
    id_use_rs = id.use_rs; id_use_rt = id.use_rt; id_wen = id.wen;
    id_waddr = ASIZE'(id.waddr); id_memread = id.memread; ex_taken = tk;
    bub = '{default: 0};
    if (model_known) begin
      lu = id.valid && pipe[0].valid && pipe[0].memread &&
           ((id.use_rs && writes(pipe[0], id.rs)) || (id.use_rt && writes(pipe[0], id.rt)));
      acc = tk && pipe[0].valid && (flush_left == 0);
      e.cycle = cycle;
      e.flush = acc || (flush_left > 0);
      e.stall = lu && !e.flush;
      e.bubble = lu || e.flush;
      e.byp_a = id.use_rs && writes(pipe[2], id.rs);
      e.byp_b = id.use_rt && writes(pipe[2], id.rt);
      e.fwd_a = fwd_src(pipe[0].rs, pipe[0].use_rs);
      e.fwd_b = fwd_src(pipe[0].rt, pipe[0].use_rt);
      e.stall_cnt = sat(n_stall, 16);
      e.flush_cnt = sat(n_flush, 16);
      e.s_stall_cnt = sat(n_stall, SMALL_W);
      e.s_flush_cnt = sat(n_flush, SMALL_W);
      exp_q.push_back(e);
      if (!r) begin
        pipe.push_front(e.bubble ? bub : id);
        void'(pipe.pop_back());
        flush_left = acc ? FLUSH_CYCLES - 1 : ((flush_left > 0) ? flush_left - 1 : 0);
        n_stall += int'(e.stall);
        n_flush += int'(acc);
      end
    end
    if (r) begin
      pipe = '{bub, bub, bub};
      flush_left = 0; n_stall = 0; n_flush = 0;
      model_known = 1;
    end
    cycle++;
  endtask

  function automatic instr_t mk(bit v, int rs, int rt, bit urs, bit urt, bit wen, int wa, bit mr);
    instr_t i;
    i.valid = v; i.rs = rs; i.rt = rt; i.use_rs = urs; i.use_rt = urt;
    i.wen = wen; i.waddr = wa; i.memread = mr;
    return i;
  endfunction

  // Monitor: compares against the scoreboard whenever the DUT presents a cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("stall", e.cycle, 32'(stall), 32'(e.stall));
        check("bubble", e.cycle, 32'(bubble), 32'(e.bubble));
        check("flush", e.cycle, 32'(flush), 32'(e.flush));
        check("fwd_a", e.cycle, 32'(fwd_a), e.fwd_a);
        check("fwd_b", e.cycle, 32'(fwd_b), e.fwd_b);
        check("id_byp_a", e.cycle, 32'(id_byp_a), 32'(e.byp_a));
        check("id_byp_b", e.cycle, 32'(id_byp_b), 32'(e.byp_b));
        check("stall_cnt", e.cycle, 32'(stall_cnt), e.stall_cnt);
        check("flush_cnt", e.cycle, 32'(flush_cnt), e.flush_cnt);
        check("small_stall_cnt", e.cycle, 32'(s_stall_cnt), e.s_stall_cnt);
        check("small_flush_cnt", e.cycle, 32'(s_flush_cnt), e.s_flush_cnt);
      end
    end
  end

  initial begin
    instr_t nop, ins;
    int wait_cycles;
    nop = mk(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, nop, 0);
    step(1, nop, 0);

    // ALU dependency on r3: MEM forward then WB forward
    step(0, mk(1, 1, 2, 1, 1, 1, 3, 0), 0);
    step(0, mk(1, 3, 4, 1, 1, 1, 5, 0), 0);
    step(0, mk(1, 0, 3, 0, 1, 1, 6, 0), 0);
    step(0, nop, 0);
    step(0, nop, 0);
    // load-use on r5: ID held for one stall cycle
    step(0, mk(1, 1, 0, 1, 0, 1, 5, 1), 0);
    step(0, mk(1, 5, 1, 1, 1, 1, 6, 0), 0);
    step(0, mk(1, 5, 1, 1, 1, 1, 6, 0), 0);
    step(0, nop, 0);
    step(0, nop, 0);
    // load into r0 followed by use of r0
    step(0, mk(1, 1, 0, 1, 0, 1, 0, 1), 0);
    step(0, mk(1, 0, 0, 1, 1, 1, 6, 0), 0);
    step(0, nop, 0);
    step(0, nop, 0);
    step(0, nop, 0);
    // taken branch, second taken inside the window is ignored
    step(0, mk(1, 1, 2, 1, 1, 0, 0, 0), 0);
    step(0, mk(1, 1, 2, 1, 1, 1, 4, 0), 1);
    step(0, mk(1, 1, 2, 1, 1, 1, 4, 0), 1);
    step(0, nop, 0);
    // load-use coinciding with a taken branch
    step(0, mk(1, 1, 0, 1, 0, 1, 5, 1), 0);
    step(0, mk(1, 5, 0, 1, 0, 1, 6, 0), 1);
    step(0, nop, 0);
    step(0, nop, 0);
    // write r7 reaches WB while ID reads r7
    step(0, mk(1, 1, 2, 1, 1, 1, 7, 0), 0);
    step(0, nop, 0);
    step(0, nop, 0);
    step(0, mk(1, 7, 7, 1, 1, 1, 8, 0), 0);
    // reset during a stall, then during a flush
    step(0, mk(1, 1, 0, 1, 0, 1, 5, 1), 0);
    step(1, mk(1, 5, 0, 1, 0, 1, 6, 0), 0);
    step(0, nop, 0);
    step(0, mk(1, 1, 2, 1, 1, 1, 4, 0), 0);
    step(1, nop, 1);
    step(0, nop, 0);

    for (int i = 0; i < 4000; i++) begin
      ins = mk(($urandom_range(0, 7) != 0), $urandom_range(0, 3), $urandom_range(0, 3),
               $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
               $urandom_range(0, 3), ($urandom_range(0, 2) == 0));
      step(($urandom_range(0, 599) == 0), ins, ($urandom_range(0, 7) == 0));
    end

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      #4;
      wait_cycles++;
    end
    if (exp_q.size() > 0) check("scoreboard_drain", cycle, 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and forwarding controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It keeps its own shadow copy of destination-register state for the EX, MEM and WB slots. From that state it generates:
- load-use stalls;
- taken-branch flushes;
- EX-stage operand forwarding selects;
- the WB-to-ID bypass.

It also keeps saturating stall and flush event counters for performance debug.

## Interface
Parameters:
- ASIZE, 5, register-address width
- FLUSH_CYCLES, 2, cycles `flush` stays high per taken branch (1..3)
- CNT_W, 16, width of event counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  ASIZE  source register addresses of the ID instruction
- id_use_rs, id_use_rt  in  1  ID instruction actually reads rs / rt
- id_wen  in  1  ID instruction writes the register file
- id_waddr  in  ASIZE  destination chosen by the regdst mux
- id_memread  in  1  ID instruction is a load
- ex_taken  in  1  branch in EX resolved taken (zero AND branch)
- stall  out  1  hold PC and IF/ID register this cycle
- bubble  out  1  load ID/EX with zeros (NOP) at next edge
- flush  out  1  invalidate IF/ID contents (wrong path)
- fwd_a, fwd_b  out  2  EX operand A/B source: 00 ID/EX data, 01 EX/MEM ALU result, 10 WB write data
- id_byp_a, id_byp_b  out  1  ID read of rs/rt must take WB write data (same-cycle write)
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Each shadow slot (EX, MEM, WB) holds {valid, wen, waddr, memread, rs, rt, use_rs, use_rt}.
- Slot writes to register 0 are treated as non-writing. They never cause a hazard, forward or bypass.
- Shift at every edge:
  - WB <= MEM
  - MEM <= EX
  - EX <= ID fields, or an invalid slot when `bubble` is high
- Load-use hazard:
  - Condition: id_valid AND EX slot valid AND memread AND wen AND waddr != 0, AND (id_use_rs AND id_rs == waddr, or id_use_rt AND id_rt == waddr).
  - Response: stall = 1 and bubble = 1 for exactly one cycle. The next cycle the load is in MEM, the hazard condition is false and the pipeline proceeds.
- Taken branch (ex_taken AND EX slot valid):
  - flush = 1 and bubble = 1 that cycle.
  - A down-counter is loaded with FLUSH_CYCLES-1. flush stays high while the counter is non-zero.
  - During the flush window, bubble = 1 and stall = 0 every cycle.
  - ex_taken is ignored while the counter is non-zero, because the EX slot is invalid then.
- Priority: flush over stall. When a load-use hazard and a taken branch occur in the same cycle, stall = 0 (the ID instruction is discarded).
- fwd_a:
  - 01 if MEM slot valid AND wen AND !memread AND waddr == EX rs AND EX use_rs AND waddr != 0.
  - Otherwise 10 if the WB slot matches the same way (memread allowed).
  - Otherwise 00.
  - fwd_b is identical using rt. MEM has priority over WB, so the youngest value wins.
- An invalid EX slot drives fwd_a = fwd_b = 00.
- id_byp_a = WB slot valid AND wen AND waddr != 0 AND waddr == id_rs AND id_use_rs. id_byp_b is the same using rt.
- Counters:
  - stall_cnt increments on each cycle with stall = 1.
  - flush_cnt increments once per accepted taken branch, not per flush cycle.
  - Both saturate at all-ones.

## Timing
- Reset: all slots invalid, flush counter 0. stall, bubble, flush, id_byp_* = 0; fwd_a = fwd_b = 00; counters = 0.
- Reset mid-operation discards all in-flight state at the edge; outputs are at reset values the next cycle.
- Output dependencies:
  - stall, bubble and id_byp_* are combinational from ID inputs and registered slots, valid in the same cycle.
  - flush follows ex_taken combinationally in the first cycle, then comes from the counter.
  - fwd_* are combinational from registered slots only.
- Stall latency: zero cycles; each load-use hazard costs exactly 1 cycle.
- Flush penalty: FLUSH_CYCLES cycles.
- Rising-edge clk only; no multicycle paths.

## Test plan
- Back-to-back ALU dependency: add r3 in EX, then sub uses r3. Next cycle fwd_a = 01. The cycle after, an instruction reading r3 gets fwd = 10. stall never asserts.
- Load-use: lw r5, then add r6, r5, r1. stall = bubble = 1 for exactly one cycle; then fwd_a = 10 for the add in EX; stall_cnt = 1.
- Register 0: lw r0, then add using r0. No stall, all fwd = 00, id_byp = 0.
- Taken branch with FLUSH_CYCLES = 2: ex_taken pulse. flush = 1 for 2 cycles, bubble = 1 for 2 cycles, flush_cnt = 1. A second ex_taken during the window is ignored.
- Simultaneous hazards:
  - Load-use hazard in the same cycle as ex_taken: stall = 0, flush = 1.
  - WB write to r7 while ID reads r7: id_byp_a = 1.
- Reset asserted during a stall and during a flush: next cycle all outputs 0. stall_cnt saturates at 0xFFFF after 65535+ forced stalls.
